floor_request_encoder: RTL
==========================

Name: floor_request_encoder

Overview:
- Producer side of the floor-request interface into the elevator controller.
- Synchronizes and debounces the raw call button (Button5) and flush button (Button4), and captures the 3-bit floor code from switch1..switch3 on each accepted press.
- Queues requests in a small FIFO, dropping duplicates.
- Presents queued requests to the controller over a valid/ready handshake.

Parameters:
- DEB_CYCLES, 4: consecutive synchronized-high cycles required to accept a button press (range 1..15).
- FIFO_DEPTH, 4: request queue entries (power of 2, 2..8).
- MAX_FLOOR, 4: highest legal floor code; larger codes are rejected.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- switch1  in  1  floor code bit 2 (MSB), raw.
- switch2  in  1  floor code bit 1, raw.
- switch3  in  1  floor code bit 0 (LSB), raw.
- Button5  in  1  raw call button; an accepted press enqueues the switch code.
- Button4  in  1  raw flush button; an accepted press empties the queue.
- req_ready  in  1  controller accepts the head request this cycle.
- req_valid  out  1  head request available.
- req_floor  out  3  head request floor code.
- fifo_count  out  4  number of queued entries.
- overflow  out  1  one-cycle pulse: valid, non-duplicate press dropped because the queue was full.
- reject  out  1  one-cycle pulse: press carried code > MAX_FLOOR.

Behaviour:
Reset
- reset low asynchronously clears synchronizers, debounce counters, FIFO pointers and storage, and all outputs.
- Output values in reset: req_valid=0, req_floor=0, fifo_count=0, overflow=0, reject=0.
- Deassertion takes effect at the next clk edge.
- Reset mid-operation discards all queued requests and any partially debounced press.

Input conditioning
- Every raw input passes through a 2-flop synchronizer.
- Per button: the counter increments while the synchronized level is 1 and saturates at DEB_CYCLES. It clears to 0 when the level is 0.
- The debounced level is 1 when the counter equals DEB_CYCLES.
- Press event: single-cycle pulse on the rising edge of the debounced level. It occurs on the edge 2+DEB_CYCLES edges after the first edge that samples the raw button high.
- A press shorter than DEB_CYCLES synchronized cycles produces no event.
- Holding a button produces exactly one event. A new event requires release to 0 for at least one synchronized cycle.
- The floor code is taken from the synchronized switches on the press-event cycle.

Call press evaluation, in priority order
- Flush event in the same cycle: the call is ignored with no pulse, and the flush executes.
- Code > MAX_FLOOR: no push; reject=1 for one cycle.
- Code equal to any currently queued entry, including the head being popped this cycle: silently dropped, no pulse.
- Queue full and no pop this cycle: no push; overflow=1 for one cycle.
- Otherwise: push at the tail.

Pop and simultaneous operations
- Pop occurs when req_valid and req_ready are both 1 on a clock edge.
- A simultaneous push and pop on a full queue succeeds: count is unchanged and no overflow.

Flush
- A flush event clears all entries on that edge; fifo_count=0 the next cycle.
- A pop in the same cycle is discarded (the head is lost).

Handshake
- req_valid = (fifo_count != 0), registered.
- req_floor = the head entry.
- While req_valid=1 and req_ready=0, req_floor stays stable until popped or flushed.
- Latency: a push into an empty queue gives req_valid=1 on the cycle after the press event.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.

Test Plan:
Conditions for all scenarios: DEB_CYCLES=4, FIFO_DEPTH=4, MAX_FLOOR=4.
1. Switches=011, Button5 high for 10 cycles, req_ready=0 -> one press event exactly 6 edges after raw high is first sampled; req_valid=1 the next cycle; req_floor=3, fifo_count=1. No second push while the button is held.
2. Button5 high for 3 cycles then low -> no event; fifo_count stays 0. Switches=110 with a valid press -> reject pulses once; queue unchanged.
3. Presses with codes 1,2,3,4,0 and req_ready=0 -> count goes 1..4; the fifth press (code 0) pulses overflow. Then hold req_ready=1 -> req_floor sequence 1,2,3,4, then req_valid=0.
4. Queue {2}, press code 2 -> no push, no pulse, count=1. Full queue {1,2,3,4} with req_ready=1 while code 0 is pressed -> pop of 1 and push of 0 in the same cycle; count stays 4, no overflow.
5. Queue {1,3}, Button4 and Button5 (code 2) pressed together -> flush wins; fifo_count=0, req_valid=0, no pulses.
6. Queue {1,3}, drive reset low mid-debounce of a new press -> all outputs 0 immediately. After release the queue is empty and the aborted press produces no event.

Source files
------------

// File: rtl/floor_request_encoder.sv
// Floor-request producer: synchronizes and debounces the call/flush buttons,
// queues floor codes without duplicates, and offers them over valid/ready.

module floor_request_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic press
);

  logic [3:0] cnt;
  logic       deb;
  logic       deb_q;

  assign deb   = (cnt == 4'(CYCLES));
  assign press = deb & ~deb_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      deb_q <= 1'b0;
    end else begin
      if (!level) begin
        cnt <= '0;
      end else if (!deb) begin
        cnt <= cnt + 4'd1;
      end
      deb_q <= deb;
    end
  end

endmodule

module floor_request_encoder #(
  parameter int DEB_CYCLES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_FLOOR  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  input  logic       Button5,
  input  logic       Button4,
  input  logic       req_ready,
  output logic       req_valid,
  output logic [2:0] req_floor,
  output logic [3:0] fifo_count,
  output logic       overflow,
  output logic       reject
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [4:0]    raw;
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [2:0]    code;
  logic          call_ev;
  logic          flush_ev;

  logic [2:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [3:0]    count;
  logic [3:0]    count_nxt;

  logic          pop;
  logic          full;
  logic          dup;
  logic          do_push;
  logic          do_ovf;
  logic          do_rej;

  assign raw = {Button4, Button5, switch1, switch2, switch3};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign code = sync2[2:0];

  floor_request_debounce #(
    .CYCLES(DEB_CYCLES)
  ) u_call_deb (
    .clk  (clk),
    .reset(reset),
    .level(sync2[3]),
    .press(call_ev)
  );

  floor_request_debounce #(
    .CYCLES(DEB_CYCLES)
  ) u_flush_deb (
    .clk  (clk),
    .reset(reset),
    .level(sync2[4]),
    .press(flush_ev)
  );

  assign pop  = req_valid & req_ready;
  assign full = (count == 4'(FIFO_DEPTH));

  // Duplicate search covers every live entry, including a head leaving now.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((4'(i) < count) && (mem[rd_ptr + PW'(i)] == code)) begin
        dup = 1'b1;
      end
    end
  end

  always_comb begin
    do_push = 1'b0;
    do_ovf  = 1'b0;
    do_rej  = 1'b0;
    if (call_ev && !flush_ev) begin
      if (code > 3'(MAX_FLOOR)) begin
        do_rej = 1'b1;
      end else if (dup) begin
        do_push = 1'b0;
      end else if (full && !pop) begin
        do_ovf = 1'b1;
      end else begin
        do_push = 1'b1;
      end
    end
  end

  always_comb begin
    count_nxt = count + {3'b0, do_push} - {3'b0, pop};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_valid <= 1'b0;
      overflow  <= 1'b0;
      reject    <= 1'b0;
    end else begin
      overflow <= do_ovf;
      reject   <= do_rej;
      if (flush_ev) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        req_valid <= 1'b0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= code;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count     <= count_nxt;
        req_valid <= (count_nxt != 4'd0);
      end
    end
  end

  assign req_floor  = mem[rd_ptr];
  assign fifo_count = count;

endmodule
